write_ptr_full_logic: RTL and testbench

WRITE_PTR_FULL_LOGIC -- requirements
Module: write_ptr_full_logic

---
 rtl/write_ptr_full_logic.sv | 79 +++++++
 tb/tb_write_ptr_full_logic.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/write_ptr_full_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : write_ptr_full_logic                                             |
// | Brief   : Async-FIFO write-side pointer, Gray export and full/level flags  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module write_ptr_full_logic #(
    parameter int address  = 2,
    parameter int af_level = (1 << address) - 1
) (
    input  logic               wclk,
    input  logic               w_rst,
    input  logic               w_en,
    input  logic [address:0]   read_ptr_gray,
    output logic [address:0]   write_ptr,
    output logic [address:0]   write_ptr_gray,
    output logic [address-1:0] waddr,
    output logic               wr_mem_en,
    output logic               full,
    output logic               almost_full,
    output logic [address:0]   level,
    output logic               overflow
);

    localparam logic [address:0] c_af_level = af_level[address:0];

    logic [address:0] r_rsync1;
    logic [address:0] r_rsync2;
    logic [address:0] w_bin_next;
    logic [address:0] w_gray_next;
    logic [address:0] w_rbin;
    logic [address:0] w_level_next;
    logic [address:0] w_full_match;
    logic             w_full_next;

    // Reset gates the strobe directly so no write can leak through while the flags clear.
    assign wr_mem_en   = w_en & ~full & ~w_rst;
    assign waddr       = write_ptr[address-1:0];
    assign w_bin_next  = write_ptr + (address + 1)'(wr_mem_en);
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= address; i++) begin
            w_rbin[i] = ^(r_rsync2 >> i);
        end
    end

    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    assign w_full_match = {~r_rsync2[address:address-1], r_rsync2[address-2:0]};
    assign w_full_next  = (w_gray_next == w_full_match);
    assign w_level_next = w_bin_next - w_rbin;

    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            r_rsync1       <= '0;
            r_rsync2       <= '0;
            write_ptr      <= '0;
            write_ptr_gray <= '0;
            level          <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            r_rsync1       <= read_ptr_gray;
            r_rsync2       <= r_rsync1;
            write_ptr      <= w_bin_next;
            write_ptr_gray <= w_gray_next;
            level          <= w_level_next;
            full           <= w_full_next;
            almost_full    <= (w_level_next >= c_af_level);
            if (w_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_ptr_full_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_write_ptr_full_logic                                          |
// | Brief   : Directed bench with occupancy-count model for write_ptr_full_logic|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_write_ptr_full_logic;

    logic       wclk = 1'b0;
    logic       w_rst = 1'b1;
    logic       w_en = 1'b0;
    logic [2:0] read_ptr_gray = 3'b000;
    logic [2:0] write_ptr;
    logic [2:0] write_ptr_gray;
    logic [1:0] waddr;
    logic       wr_mem_en;
    logic       full;
    logic       almost_full;
    logic [2:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Model state: plain integer pointers and occupancy.
    int m_wp, m_rs1, m_rs2, m_level;
    bit m_full, m_af, m_ovf;
    bit cmp_en = 1'b0;

    write_ptr_full_logic #(.address(2), .af_level(3)) dut (
        .wclk(wclk), .w_rst(w_rst), .w_en(w_en), .read_ptr_gray(read_ptr_gray),
        .write_ptr(write_ptr), .write_ptr_gray(write_ptr_gray), .waddr(waddr),
        .wr_mem_en(wr_mem_en), .full(full), .almost_full(almost_full),
        .level(level), .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    function automatic int to_gray(int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    function automatic int from_gray(int g);
        return (g ^ (g >> 1) ^ (g >> 2)) & 7;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            m_wp = 0; m_rs1 = 0; m_rs2 = 0; m_level = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (w_en && m_full) m_ovf = 1;
            if (w_en && !m_full) m_wp = (m_wp + 1) % 8;
            m_level = (m_wp - m_rs2 + 8) % 8;
            m_full  = (m_level == 4);
            m_af    = (m_level >= 3);
            m_rs2   = m_rs1;
            m_rs1   = from_gray(int'(read_ptr_gray));
        end
    end

    always @(negedge wclk) begin
        if (cmp_en && !w_rst) begin
            chk("m_write_ptr", write_ptr, m_wp);
            chk("m_write_ptr_gray", write_ptr_gray, to_gray(m_wp));
            chk("m_waddr", waddr, m_wp % 4);
            chk("m_level", level, m_level);
            chk("m_full", full, m_full);
            chk("m_almost_full", almost_full, m_af);
            chk("m_overflow", overflow, m_ovf);
            chk("m_wr_mem_en", wr_mem_en, w_en && !m_full);
        end
    end

    // Advance one edge and settle away from both clock edges.
    task automatic step();
        @(posedge wclk);
        #2;
    endtask

    task automatic set_rp(int b);
        read_ptr_gray = 3'(to_gray(b));
    endtask

    initial begin
        logic [2:0] prev_g;
        int diff_bits;
        int false_full;

        step();
        w_rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_write_ptr", write_ptr, 0);
        chk("reset_level", level, 0);

        // Mid-operation reset with w_en high, between edges.
        w_en = 1'b1;
        step(); step();
        chk("pre_reset_write_ptr", write_ptr, 2);
        w_rst = 1'b1;
        #1;
        chk("rst_write_ptr", write_ptr, 0);
        chk("rst_write_ptr_gray", write_ptr_gray, 0);
        chk("rst_flags", {full, almost_full, overflow}, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_mem_en", wr_mem_en, 0);
        w_rst = 1'b0;

        // Fill four entries.
        for (int k = 0; k < 4; k++) begin
            chk("fill_waddr", waddr, k);
            step();
            if (k == 2) begin
                chk("fill_af_e3", almost_full, 1);
                chk("fill_level_e3", level, 3);
                chk("fill_full_e3", full, 0);
            end
        end
        chk("fill_full", full, 1);
        chk("fill_write_ptr", write_ptr, 3'b100);
        chk("fill_write_ptr_gray", write_ptr_gray, 3'b110);

        // Overflow attempts.
        chk("ovf_wr_mem_en", wr_mem_en, 0);
        step(); step();
        chk("ovf_write_ptr", write_ptr, 3'b100);
        chk("ovf_flag", overflow, 1);
        w_en = 1'b0;
        step();
        chk("ovf_sticky", overflow, 1);

        // Release: one read seen after three edges.
        set_rp(1);
        step();
        step();
        chk("rel_full_e2", full, 1);
        step();
        chk("rel_full_e3", full, 0);
        chk("rel_level_e3", level, 3);

        // Wrap from a clean reset with the read pointer trailing.
        w_rst = 1'b1;
        #1;
        set_rp(0);
        w_rst = 1'b0;
        w_en = 1'b1;
        false_full = 0;
        prev_g = write_ptr_gray;
        for (int k = 0; k < 8; k++) begin
            set_rp(k);
            step();
            diff_bits = $countones(write_ptr_gray ^ prev_g);
            chk("wrap_gray_onebit", diff_bits, 1);
            prev_g = write_ptr_gray;
            if (full) false_full++;
        end
        chk("wrap_write_ptr", write_ptr, 0);
        chk("wrap_write_ptr_gray", write_ptr_gray, 0);
        chk("wrap_no_false_full", false_full, 0);

        // Simultaneous: settle at level 3, then write as synced read advances.
        w_en = 1'b0;
        set_rp(5);
        step(); step(); step();
        chk("sim_level_pre", level, 3);
        set_rp(6);
        step(); step();
        w_en = 1'b1;
        step();
        chk("sim_level", level, 3);
        chk("sim_full", full, 0);
        chk("sim_write_ptr", write_ptr, 1);
        w_en = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
